// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings and the NZCV flag bundle used by the
// pipelined adder/subtractor.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
    } flags_t;

    // Subtracting forms invert B and feed the chain through the carry-in.
    function automatic logic op_inverts_b(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SBB);
    endfunction

endpackage

// File: rtl/add_sub_slice.sv
// One CHUNK-bit slice of the carry chain: sum, carry-out and a slice-zero
// indication for the running zero flag.
module add_sub_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             zero
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        zero        = (sum == '0);
    end

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined adder/subtractor, one CHUNK-bit carry slice per stage, with
// valid/ready back-pressure and NZCV flags. Optional sticky overflow flag is
// built when ADD_SUB_PIPE_STICKY_OVF_EN is defined.
module add_sub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    localparam int NSTAGE = WIDTH / CHUNK;
    localparam int LAST   = NSTAGE - 1;
    localparam int MSB    = WIDTH - 1;

    // Stage registers: partial result, operands carried forward, carry, zero AND.
    logic             v_q [NSTAGE];
    logic [WIDTH-1:0] r_q [NSTAGE];
    logic [WIDTH-1:0] a_q [NSTAGE];
    logic [WIDTH-1:0] b_q [NSTAGE];
    logic             c_q [NSTAGE];
    logic             z_q [NSTAGE];

    logic             v_in [NSTAGE];
    logic [WIDTH-1:0] r_in [NSTAGE];
    logic [WIDTH-1:0] a_in [NSTAGE];
    logic [WIDTH-1:0] b_in [NSTAGE];
    logic             c_in [NSTAGE];
    logic             z_in [NSTAGE];
    logic [CHUNK-1:0] s_sum  [NSTAGE];
    logic             s_cout [NSTAGE];
    logic             s_zero [NSTAGE];

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    flags_t           flags;

    assign stall    = v_q[LAST] && !out_ready;
    assign in_ready = !stall;

    always_comb begin
        b_eff = op_inverts_b(op) ? ~b : b;
        c0    = 1'b0;
        case (op)
            OP_ADD:  c0 = 1'b0;
            OP_SUB:  c0 = 1'b1;
            OP_ADC:  c0 = cin;
            OP_SBB:  c0 = cin;
            default: c0 = 1'b0;
        endcase
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign v_in[k] = in_valid;
            assign a_in[k] = a;
            assign b_in[k] = b_eff;
            assign r_in[k] = '0;
            assign c_in[k] = c0;
            assign z_in[k] = 1'b1;
        end else begin : g_next
            assign v_in[k] = v_q[k-1];
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign r_in[k] = r_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign z_in[k] = z_q[k-1];
        end

        add_sub_slice #(.CHUNK(CHUNK)) u_slice (
            .a    (a_in[k][k*CHUNK +: CHUNK]),
            .b    (b_in[k][k*CHUNK +: CHUNK]),
            .cin  (c_in[k]),
            .sum  (s_sum[k]),
            .cout (s_cout[k]),
            .zero (s_zero[k])
        );
    end

    // Data registers load only behind a valid token so idle inputs never reach out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSTAGE; i++) begin
                v_q[i] <= 1'b0;
                r_q[i] <= '0;
                a_q[i] <= '0;
                b_q[i] <= '0;
                c_q[i] <= 1'b0;
                z_q[i] <= 1'b0;
            end
        end else if (!stall) begin
            for (int i = 0; i < NSTAGE; i++) begin
                v_q[i] <= v_in[i];
                if (v_in[i]) begin
                    r_q[i]                  <= r_in[i];
                    r_q[i][i*CHUNK +: CHUNK] <= s_sum[i];
                    a_q[i]                  <= a_in[i];
                    b_q[i]                  <= b_in[i];
                    c_q[i]                  <= s_cout[i];
                    z_q[i]                  <= z_in[i] & s_zero[i];
                end
            end
        end
    end

    assign flags.carry = c_q[LAST];
    assign flags.zero  = z_q[LAST];
    assign flags.neg   = r_q[LAST][MSB];
    assign flags.ovf   = (a_q[LAST][MSB] == b_q[LAST][MSB]) &&
                         (r_q[LAST][MSB] != a_q[LAST][MSB]);

    assign out_valid = v_q[LAST];
    assign out       = r_q[LAST];
    assign carry     = flags.carry;
    assign zero      = flags.zero;
    assign neg       = flags.neg;
    assign ovf       = flags.ovf;

`ifdef ADD_SUB_PIPE_STICKY_OVF_EN
    logic sticky_q;

    // Set has priority over clear when both land in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (out_valid && out_ready && flags.ovf) begin
            sticky_q <= 1'b1;
        end else if (clr_sticky) begin
            sticky_q <= 1'b0;
        end
    end

    assign ovf_sticky = sticky_q;
`else
    logic unused_clr_sticky;

    assign unused_clr_sticky = clr_sticky;
    assign ovf_sticky        = 1'b0;
`endif

endmodule

// File: tb/tb_add_sub_pipe.sv
// Scoreboard bench for add_sub_pipe (WIDTH=32, CHUNK=8): directed vectors,
// back-pressure stream, mid-flight reset, optional sticky overflow.
module tb_add_sub_pipe;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NSTAGE = WIDTH / CHUNK;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] ADC = 2'b10;
    localparam logic [1:0] SBB = 2'b11;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             ovf_sticky;
    logic             clr_sticky;

    add_sub_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .cin        (cin),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .carry      (carry),
        .zero       (zero),
        .neg        (neg),
        .ovf        (ovf),
        .ovf_sticky (ovf_sticky),
        .clr_sticky (clr_sticky)
    );

    typedef struct {
        logic [35:0] res;
        int          issue;
        int          stalls;
    } exp_t;

    exp_t        q[$];
    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    int          stall_cnt = 0;
    int          stall_base = 0;
    bit          stall_on  = 0;
    bit          held_valid = 0;
    logic [35:0] held;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // out_ready is dropped for a fixed window relative to stall_base.
    initial forever begin
        @(negedge clk);
        out_ready = !(stall_on && (cyc - stall_base) >= 6 && (cyc - stall_base) <= 9);
    end

    // Monitor: pops the scoreboard on every output transfer.
    initial forever begin
        exp_t e;
        logic [35:0] got;
        @(negedge clk);
        #1;
        if (rst_n !== 1'b1) begin
            held_valid = 0;
        end else begin
            got = {out, carry, zero, neg, ovf};
            if (out_valid && held_valid)
                chk("held_stable", 64'(got), 64'(held));
            if (out_valid && !out_ready) begin
                stall_cnt++;
                chk("in_ready_stall", 64'(in_ready), 64'd0);
                held_valid = 1;
                held = got;
            end else begin
                held_valid = 0;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 64'(got), 64'hDEAD);
                end else begin
                    e = q.pop_front();
                    chk("result", 64'(got), 64'(e.res));
                    chk("latency", 64'(cyc + 1 - e.issue),
                        64'(NSTAGE + stall_cnt - e.stalls));
`ifndef ADD_SUB_PIPE_STICKY_OVF_EN
                    chk("sticky_tied", 64'(ovf_sticky), 64'd0);
`endif
                end
            end
        end
    end

    task automatic send(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic ci, input logic [31:0] eo, input logic [3:0] ef);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        op = o; a = x; b = y; cin = ci; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            e.res    = {eo, ef};
            e.issue  = cyc + 1;
            e.stalls = stall_cnt;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            op = 2'($urandom_range(3));
            a = $urandom; b = $urandom; cin = 1'($urandom_range(1));
        end
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while (q.size() != 0 && n < 200) begin
            idle(1);
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        idle(2);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = ADD; cin = 1'b0; a = '0; b = '0;
        clr_sticky = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_flags", 64'({carry, zero, neg, ovf}), 64'd0);
        chk("rst_sticky", 64'(ovf_sticky), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // flags order: carry zero neg ovf
        send(ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1100);
        idle(2);
        send(SUB, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 4'b0010);
        send(SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b1001);
        send(ADC, 32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0100, 4'b0000);
        idle(1);
        send(SBB, 32'h0000_000A, 32'h0000_0003, 1'b0, 32'h0000_0006, 4'b1000);
        send(ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0011);
        send(SUB, 32'h0000_0003, 32'h0000_0003, 1'b0, 32'h0000_0000, 4'b1100);
        send(ADC, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b1100);
        send(SBB, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 4'b0010);
        send(ADC, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 4'b0000);
        drain();

        stall_base = cyc;
        stall_on   = 1;
        for (int i = 0; i < 8; i++)
            send(ADD, 32'h0000_00F0 + 32'(i), 32'h0000_0010, 1'b0,
                 32'h0000_0100 + 32'(i), 4'b0000);
        drain();
        chk("stall_seen", 64'(stall_cnt > 0), 64'd1);

        send(ADD, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 4'b0000);
        send(SUB, 32'h0000_0009, 32'h0000_0004, 1'b0, 32'h0000_0005, 4'b1000);
        send(ADD, 32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 4'b0000);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out", 64'(out), 64'd0);
        rst_n = 1'b1;
        idle(10);
        chk("flush_no_stale", 64'(q.size()), 64'd0);

        send(SBB, 32'h0000_0064, 32'h0000_0064, 1'b1, 32'h0000_0000, 4'b1100);
        drain();

`ifdef ADD_SUB_PIPE_STICKY_OVF_EN
        send(ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0011);
        send(ADD, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 4'b0000);
        drain();
        chk("sticky_holds", 64'(ovf_sticky), 64'd1);
        @(negedge clk);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        #1;
        chk("sticky_cleared", 64'(ovf_sticky), 64'd0);
        @(negedge clk);
        clr_sticky = 1'b1;
        send(SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b1001);
        drain();
        chk("sticky_set_wins", 64'(ovf_sticky), 64'd1);
        clr_sticky = 1'b0;
        idle(1);
        #1;
        chk("sticky_after_win", 64'(ovf_sticky), 64'd1);
`else
        chk("sticky_off", 64'(ovf_sticky), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/add_sub_pipe.md
Name: add_sub_pipe

Overview:
- Parametrised, pipelined successor to the combinational 32-bit adder/subtractor in the ALU datapath.
- Splits the carry chain into CHUNK-bit slices, one slice per pipeline stage, so the adder closes timing at wide WIDTH.
- Adds a valid/ready handshake with back-pressure, carry/borrow-in ops, and full NZCV flags.
- Sits between operand fetch and writeback in the execution unit.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 8, bits added per pipeline stage. NSTAGE = WIDTH/CHUNK, which is both the stage count and the latency.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands and op are valid this cycle.
- in_ready  out  1  block accepts input this cycle.
- op  in  2  operation: 00 ADD a+b; 01 SUB a-b; 10 ADC a+b+cin; 11 SBB a-b-!cin.
- cin  in  1  carry-in; used by ADC/SBB only.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  downstream accepts the result.
- out  out  WIDTH  result, modulo 2^WIDTH.
- carry  out  1  carry-out of bit WIDTH-1. For SUB/SBB this is the a+~b+1 convention: 1 means no borrow.
- zero  out  1  out == 0.
- neg  out  1  out[WIDTH-1].
- ovf  out  1  signed overflow.
- ovf_sticky  out  1  sticky overflow (Optional Feature only; tied 0 otherwise).
- clr_sticky  in  1  clears ovf_sticky (Optional Feature only; ignored otherwise).

Behaviour:
- Reset: clk is the only clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
  - All stage valid bits cleared.
  - out_valid=0, out=0, carry=0, zero=0, neg=0, ovf=0, ovf_sticky=0.
  - Reset asserted mid-operation discards every in-flight transaction, with no output for them.
- Operand preparation at acceptance:
  - b_eff = b for ADD/ADC, ~b for SUB/SBB.
  - c0 = 0 for ADD, 1 for SUB, cin for ADC, cin for SBB (SBB: a + ~b + cin).
- Stage k (k=0..NSTAGE-1):
  - Computes {c_k+1, r[k*CHUNK +: CHUNK]} = a_slice + b_eff_slice + c_k.
  - Registers the partial result, the untouched upper operand slices, the carry, and a running zero AND.
- Final stage:
  - carry = c_NSTAGE.
  - zero = running AND of all slice-zero bits.
  - neg = result MSB.
  - ovf = (a[MSB] == b_eff[MSB]) && (out[MSB] != a[MSB]).
- Latency: exactly NSTAGE cycles from acceptance to out_valid when there is no stall. Throughput is 1 per cycle.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - stall = out_valid && !out_ready. in_ready = !stall (combinational).
  - On stall every stage register holds its value. Outputs stay stable while out_valid=1 and out_ready=0.
  - Bubbles propagate as valid=0 and are not compressed.
- in_valid without acceptance: inputs are ignored. Values of op/a/b/cin while in_valid=0 never affect any output.
- Wrap-around:
  - 0xFFFFFFFF+1 gives out=0, carry=1, zero=1.
  - Result is always truncated to WIDTH.
- WIDTH==CHUNK: NSTAGE=1, single-register block, latency 1.

Optional Feature:
- Macro ADD_SUB_PIPE_STICKY_OVF_EN.
- Defined:
  - ovf_sticky sets on any output transfer with ovf=1.
  - It clears synchronously on clr_sticky=1.
  - When a set and a clear happen in the same cycle, set wins.
  - Reset clears it.
- Undefined: ovf_sticky is constant 0, clr_sticky is unused, and no flops are added.

Decomposition:
- Shared package (alu_pkg): op encoding constants OP_ADD=2'b00, OP_SUB=2'b01, OP_ADC=2'b10, OP_SBB=2'b11, plus a flags struct {carry, zero, neg, ovf}.
- One natural sub-module, add_sub_slice: a combinational CHUNK-bit adder with carry-in/carry-out and a slice-zero output, instantiated NSTAGE times by a generate loop.

Test Plan (WIDTH=32, CHUNK=8, latency 4):
- ADD a=0xFFFFFFFF, b=1 -> after 4 cycles out=0, carry=1, zero=1, neg=0, ovf=0.
- SUB a=5, b=7 -> out=0xFFFFFFFE, carry=0 (borrow), neg=1, ovf=0. SUB a=0x80000000, b=1 -> out=0x7FFFFFFF, ovf=1, carry=1.
- ADC a=0x000000FF, b=0, cin=1 -> out=0x100, with carry crossing the slice boundary. SBB a=10, b=3, cin=0 -> out=6.
- Back-to-back stream of 8 ADDs, with out_ready held low for cycles 6-9 -> in_ready=0 during the stall, outputs held stable, all 8 results delivered in order with none lost or duplicated.
- Assert rst_n=0 for 1 cycle with 3 transactions in flight -> out_valid=0 next cycle and no stale results afterwards.
- With ADD_SUB_PIPE_STICKY_OVF_EN: an overflowing ADD followed by a clean ADD -> ovf_sticky stays 1. Pulse clr_sticky -> ovf_sticky returns to 0. Clear coinciding with an overflowing transfer -> ovf_sticky remains 1.
